// File: rtl/noise_fill_scheduler.sv
// Walks the masked noise layers in ascending size code: launches the filler, relocates its writes
// into a contiguous per-layer BRAM region, and records each region's base. Writes land 1 cycle after fill_we.
module noise_fill_scheduler #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 14,
    parameter int DEPTH      = 16384
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic [7:0]            layer_mask,
    input  logic                  abort,
    output logic                  fill_start,
    output logic [2:0]            fill_size,
    input  logic [ADDR_WIDTH-1:0] fill_addr,
    input  logic [DATA_WIDTH-1:0] fill_wdata,
    input  logic                  fill_we,
    input  logic                  fill_done,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_wdata,
    output logic                  bram_we,
    input  logic [2:0]            rd_layer,
    output logic [ADDR_WIDTH-1:0] rd_base,
    output logic [7:0]            layer_ready,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err
);

    localparam int SW = ADDR_WIDTH + 1;
    localparam logic [SW-1:0] DEPTH_W = SW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT, S_COMMIT, S_NEXT, S_FIN, S_ERR
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [7:0]            mask_q;
    logic [2:0]            cur;
    logic [SW-1:0]         base;
    logic [SW-1:0]         wcnt;
    logic [ADDR_WIDTH-1:0] base_table [8];

    logic [SW-1:0]         wr_sum;
    logic                  ovf;
    logic [2:0]            low_bit;
    logic [2:0]            next_bit;
    logic                  any_low;
    logic                  any_next;
    logic                  to_err;

    // Extra bit on the sum so a relocation past the top of the BRAM is seen, not wrapped.
    assign wr_sum  = base + {1'b0, fill_addr};
    assign ovf     = (wr_sum >= DEPTH_W);
    assign to_err  = (state_nxt == S_ERR) && (state != S_ERR);
    assign rd_base = base_table[rd_layer];
    assign fill_size = cur;

    always_comb begin
        low_bit  = 3'd0;
        any_low  = 1'b0;
        next_bit = 3'd0;
        any_next = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (layer_mask[i]) begin
                low_bit = 3'(i);
                any_low = 1'b1;
            end
            if (mask_q[i] && (3'(i) > cur)) begin
                next_bit = 3'(i);
                any_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        fill_start = 1'b0;
        frame_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (frame_start) state_nxt = any_low ? S_LAUNCH : S_FIN;
            end
            S_LAUNCH: begin
                if (abort) state_nxt = S_ERR;
                else begin
                    fill_start = 1'b1;
                    state_nxt  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort || (fill_we && ovf)) state_nxt = S_ERR;
                else if (fill_done)            state_nxt = S_COMMIT;
            end
            S_COMMIT: state_nxt = abort ? S_ERR : S_NEXT;
            S_NEXT: begin
                if (abort)         state_nxt = S_ERR;
                else if (any_next) state_nxt = S_LAUNCH;
                else               state_nxt = S_FIN;
            end
            S_FIN: begin
                if (abort) state_nxt = S_ERR;
                else begin
                    frame_done = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q      <= '0;
            cur         <= '0;
            base        <= '0;
            wcnt        <= '0;
            layer_ready <= '0;
            busy        <= 1'b0;
            err         <= 1'b0;
            bram_addr   <= '0;
            bram_wdata  <= '0;
            bram_we     <= 1'b0;
            for (int i = 0; i < 8; i++) base_table[i] <= '0;
        end else begin
            bram_we <= 1'b0;
            if (to_err) begin
                err  <= 1'b1;
                busy <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (frame_start) begin
                            mask_q      <= layer_mask;
                            layer_ready <= '0;
                            err         <= 1'b0;
                            base        <= '0;
                            wcnt        <= '0;
                            busy        <= 1'b1;
                            cur         <= low_bit;
                        end
                    end
                    S_WAIT: begin
                        if (fill_we) begin
                            bram_addr  <= wr_sum[ADDR_WIDTH-1:0];
                            bram_wdata <= fill_wdata;
                            bram_we    <= 1'b1;
                            wcnt       <= wcnt + 1'b1;
                        end
                    end
                    S_COMMIT: begin
                        base_table[cur]  <= base[ADDR_WIDTH-1:0];
                        layer_ready[cur] <= 1'b1;
                        base             <= base + wcnt;
                        wcnt             <= '0;
                    end
                    S_NEXT: begin
                        if (any_next) cur <= next_bit;
                    end
                    S_FIN:   busy <= 1'b0;
                    S_ERR:   busy <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_noise_fill_scheduler.sv
// Directed bench: a full-depth instance and a DEPTH=8 instance share all stimulus.
module tb_noise_fill_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_start;
    logic [7:0]  layer_mask;
    logic        abort;
    logic [13:0] fill_addr;
    logic [63:0] fill_wdata;
    logic        fill_we;
    logic        fill_done;
    logic [2:0]  rd_layer;

    logic        fill_start, busy, frame_done, err, bram_we;
    logic [2:0]  fill_size;
    logic [13:0] bram_addr, rd_base;
    logic [63:0] bram_wdata;
    logic [7:0]  layer_ready;

    logic        fill_start_s, busy_s, frame_done_s, err_s, bram_we_s;
    logic [2:0]  fill_size_s;
    logic [13:0] bram_addr_s, rd_base_s;
    logic [63:0] bram_wdata_s;
    logic [7:0]  layer_ready_s;

    int total = 0;
    int bad   = 0;
    int fd_cnt = 0;
    int fd_cnt_s = 0;
    int fd_ref;
    int fd_ref_s;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done)   fd_cnt++;
        if (frame_done_s) fd_cnt_s++;
    end

    noise_fill_scheduler #(.DATA_WIDTH(64), .ADDR_WIDTH(14), .DEPTH(16384)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .layer_mask(layer_mask),
        .abort(abort), .fill_start(fill_start), .fill_size(fill_size),
        .fill_addr(fill_addr), .fill_wdata(fill_wdata), .fill_we(fill_we),
        .fill_done(fill_done), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
        .bram_we(bram_we), .rd_layer(rd_layer), .rd_base(rd_base),
        .layer_ready(layer_ready), .busy(busy), .frame_done(frame_done), .err(err)
    );

    noise_fill_scheduler #(.DATA_WIDTH(64), .ADDR_WIDTH(14), .DEPTH(8)) dut_s (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .layer_mask(layer_mask),
        .abort(abort), .fill_start(fill_start_s), .fill_size(fill_size_s),
        .fill_addr(fill_addr), .fill_wdata(fill_wdata), .fill_we(fill_we),
        .fill_done(fill_done), .bram_addr(bram_addr_s), .bram_wdata(bram_wdata_s),
        .bram_we(bram_we_s), .rd_layer(rd_layer), .rd_base(rd_base_s),
        .layer_ready(layer_ready_s), .busy(busy_s), .frame_done(frame_done_s), .err(err_s)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_launch(input int sz);
        int k = 0;
        while (!fill_start && k < 16) begin
            step();
            k++;
        end
        chk("launch_seen", 64'(fill_start), 64'd1);
        chk("fill_size", 64'(fill_size), 64'(sz));
        step();
        chk("start_one_cycle", 64'(fill_start), 64'd0);
    endtask

    task automatic write_words(input int n, input int base, input int sz);
        for (int i = 0; i < n; i++) begin
            fill_we    = 1'b1;
            fill_addr  = 14'(i);
            fill_wdata = {32'hC0DE_0000 + 32'(sz), 32'(i)};
            fill_done  = (i == n - 1);
            step();
            chk("wr_we", 64'(bram_we), 64'd1);
            chk("wr_addr", 64'(bram_addr), 64'(base + i));
            chk("wr_data", bram_wdata, {32'hC0DE_0000 + 32'(sz), 32'(i)});
        end
        fill_we   = 1'b0;
        fill_done = 1'b0;
    endtask

    task automatic start_frame(input logic [7:0] m);
        layer_mask  = m;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic finish_frame(input logic [7:0] exp_ready);
        step();
        chk("layer_ready", 64'(layer_ready), 64'(exp_ready));
        chk("we_idle_after_commit", 64'(bram_we), 64'd0);
        step();
        chk("frame_done_pulse", 64'(frame_done), 64'd1);
        step();
        chk("frame_done_single", 64'(frame_done), 64'd0);
        chk("busy_end", 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; layer_mask = '0; abort = 1'b0;
        fill_addr = '0; fill_wdata = '0; fill_we = 1'b0; fill_done = 1'b0; rd_layer = '0;
        step(); step();
        chk("rst_bram_we", 64'(bram_we), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(layer_ready), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_fill_start", 64'(fill_start), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_rd_base", 64'(rd_base), 64'd0);
        rst_n = 1'b1;
        step();

        // single layer, size 1
        start_frame(8'h02);
        wait_launch(1);
        write_words(4, 0, 1);
        finish_frame(8'h02);
        rd_layer = 3'd1; #1;
        chk("t1_rd_base1", 64'(rd_base), 64'd0);

        // two layers: size 2 region follows size 1
        start_frame(8'h06);
        wait_launch(1);
        write_words(4, 0, 1);
        wait_launch(2);
        write_words(16, 4, 2);
        finish_frame(8'h06);
        rd_layer = 3'd2; #1;
        chk("t2_rd_base2", 64'(rd_base), 64'd4);
        chk("t2_err", 64'(err), 64'd0);

        // empty mask
        fd_ref = fd_cnt;
        layer_mask  = 8'h00;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("t3_frame_done", 64'(frame_done), 64'd1);
        chk("t3_busy", 64'(busy), 64'd1);
        chk("t3_no_start", 64'(fill_start), 64'd0);
        step();
        chk("t3_busy_low", 64'(busy), 64'd0);
        chk("t3_fd_count", 64'(fd_cnt - fd_ref), 64'd1);

        // overflow on the DEPTH=8 instance
        fd_ref_s = fd_cnt_s;
        start_frame(8'h06);
        wait_launch(1);
        write_words(4, 0, 1);
        wait_launch(2);
        for (int i = 0; i < 16; i++) begin
            fill_we = 1'b1; fill_addr = 14'(i); fill_wdata = 64'(i); fill_done = (i == 15);
            step();
            if (i < 4) begin
                chk("t4_s_we", 64'(bram_we_s), 64'd1);
                chk("t4_s_addr", 64'(bram_addr_s), 64'(4 + i));
            end else if (i == 4) begin
                chk("t4_s_suppressed", 64'(bram_we_s), 64'd0);
                chk("t4_s_err", 64'(err_s), 64'd1);
                chk("t4_s_busy", 64'(busy_s), 64'd0);
            end else begin
                chk("t4_s_ignored", 64'(bram_we_s), 64'd0);
            end
        end
        fill_we = 1'b0; fill_done = 1'b0;
        step(); step(); step();
        chk("t4_s_ready", 64'(layer_ready_s), 64'h02);
        chk("t4_s_no_done", 64'(fd_cnt_s - fd_ref_s), 64'd0);
        chk("t4_s_err_sticky", 64'(err_s), 64'd1);
        chk("t4_main_ready", 64'(layer_ready), 64'h06);
        chk("t4_main_err", 64'(err), 64'd0);

        // re-pulsed frame_start ignored, then abort
        fd_ref = fd_cnt;
        start_frame(8'h0A);
        chk("t5_err_cleared", 64'(err), 64'd0);
        wait_launch(1);
        frame_start = 1'b1; layer_mask = 8'h04;
        step();
        frame_start = 1'b0;
        chk("t5_busy", 64'(busy), 64'd1);
        write_words(4, 0, 1);
        wait_launch(3);
        fill_we = 1'b1; fill_addr = 14'd0; fill_wdata = 64'h55;
        step();
        chk("t5_addr", 64'(bram_addr), 64'd4);
        abort = 1'b1; fill_addr = 14'd1;
        step();
        abort = 1'b0; fill_we = 1'b0;
        chk("t5_abort_err", 64'(err), 64'd1);
        chk("t5_abort_busy", 64'(busy), 64'd0);
        chk("t5_abort_we", 64'(bram_we), 64'd0);
        chk("t5_ready", 64'(layer_ready), 64'h02);
        step(); step();
        chk("t5_no_done", 64'(fd_cnt - fd_ref), 64'd0);

        // async reset mid-write
        start_frame(8'h02);
        wait_launch(1);
        fill_we = 1'b1; fill_addr = 14'd0; fill_wdata = 64'h77;
        step();
        chk("t6_we_before", 64'(bram_we), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_we", 64'(bram_we), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_ready", 64'(layer_ready), 64'd0);
        chk("t6_rst_start", 64'(fill_start), 64'd0);
        fill_we = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        start_frame(8'h04);
        wait_launch(2);
        write_words(4, 0, 2);
        finish_frame(8'h04);
        rd_layer = 3'd2; #1;
        chk("t6_rd_base2", 64'(rd_base), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
